// File: rtl/hilbert_pkg.sv
// Shared Q9.10 angle-format constants and helpers for the HilbertFilter datapath.
// Imported by phasecalc and freqest so both sides agree on the angle encoding.
package hilbert_pkg;

  localparam int ANGLE_W    = 19;
  localparam int ANGLE_FRAC = 10;
  localparam int DEG180     = 180 << ANGLE_FRAC;
  localparam int DEG360     = 2 * DEG180;

  localparam logic signed [ANGLE_W:0] RAW_180 = (ANGLE_W+1)'(DEG180);
  localparam logic signed [ANGLE_W:0] RAW_360 = (ANGLE_W+1)'(DEG360);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Difference folded into (-180,+180]; after the fold it always fits back in ANGLE_W bits.
  function automatic logic signed [ANGLE_W-1:0] wrap_diff(
    input logic signed [ANGLE_W-1:0] c,
    input logic signed [ANGLE_W-1:0] p
  );
    logic signed [ANGLE_W:0] raw;
    raw = {c[ANGLE_W-1], c} - {p[ANGLE_W-1], p};
    if (raw > RAW_180)
      raw = raw - RAW_360;
    else if (raw <= -RAW_180)
      raw = raw + RAW_360;
    return raw[ANGLE_W-1:0];
  endfunction

endpackage

// File: rtl/freqest_if.sv
// Connection between phasecalc (master) and freqest (slave): angle in, frequency
// estimates out.
interface freqest_if;
  import hilbert_pkg::*;

  logic                      busy;
  logic signed [ANGLE_W-1:0] angle;
  logic signed [ANGLE_W-1:0] delta;
  logic                      delta_valid;
  logic signed [ANGLE_W-1:0] avg;
  logic                      avg_valid;

  modport master (output busy, angle, input delta, delta_valid, avg, avg_valid);
  modport slave  (input busy, angle, output delta, delta_valid, avg, avg_valid);
endinterface

// File: rtl/phasewrap.sv
// Registered wrapped phase-difference stage: one delta per valid cur/prev pair.
module phasewrap
  import hilbert_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      valid,
  input  logic signed [ANGLE_W-1:0] cur,
  input  logic signed [ANGLE_W-1:0] prev,
  output logic signed [ANGLE_W-1:0] delta,
  output logic                      delta_valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      delta       <= '0;
      delta_valid <= 1'b0;
    end else begin
      delta_valid <= valid;
      if (valid)
        delta <= wrap_diff(cur, prev);
    end
  end

endmodule

// File: rtl/freqest.sv
// Instantaneous-frequency estimator: detects phasecalc completion, emits the wrapped
// per-sample phase step and the mean over 2^LOG2N steps.
module freqest
  import hilbert_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input logic      clock,
  input logic      reset,
  freqest_if.slave bus
);

  localparam int ACC_W = ANGLE_W + LOG2N;

  state_t                    state;
  logic                      busy_q;
  logic                      done;
  logic signed [ANGLE_W-1:0] prev;
  logic signed [ANGLE_W-1:0] cur;
  logic                      cur_valid;
  logic signed [ANGLE_W-1:0] delta;
  logic                      delta_valid;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic [LOG2N-1:0]          cnt;
  logic signed [ANGLE_W-1:0] avg;
  logic                      avg_valid;

  assign done = busy_q & ~bus.busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= 1'b0;
      state     <= ST_FIRST;
      prev      <= '0;
      cur       <= '0;
      cur_valid <= 1'b0;
    end else begin
      busy_q    <= bus.busy;
      cur_valid <= 1'b0;
      // prev advances in the same cycle phasewrap consumes the cur/prev pair
      if (cur_valid)
        prev <= cur;
      case (state)
        ST_FIRST: if (done) begin
          prev  <= bus.angle;
          state <= ST_RUN;
        end
        ST_RUN: if (done) begin
          cur       <= bus.angle;
          cur_valid <= 1'b1;
        end
        default: state <= ST_FIRST;
      endcase
    end
  end

  phasewrap u_phasewrap (
    .clock       (clock),
    .reset       (reset),
    .valid       (cur_valid),
    .cur         (cur),
    .prev        (prev),
    .delta       (delta),
    .delta_valid (delta_valid)
  );

  assign sum = acc + {{LOG2N{delta[ANGLE_W-1]}}, delta};

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (delta_valid) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          avg       <= ANGLE_W'(sum >>> LOG2N);
          avg_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign bus.delta       = delta;
  assign bus.delta_valid = delta_valid;
  assign bus.avg         = avg;
  assign bus.avg_valid   = avg_valid;

endmodule

// File: doc/freqest.md
# freqest

Instantaneous-frequency estimator sitting directly downstream of `phasecalc` in the HilbertFilter datapath. It detects each completed phase calculation from `busy` and captures `angle`. It then computes the wrapped phase difference from the previous result, which is the per-sample frequency in degrees/sample. It also accumulates 2^LOG2N differences and outputs their average.

## Interface
- LOG2N, default 3: log2 of the averaging window. Legal range 1..8.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- busy  in  1  `busy` from phasecalc. A 1→0 transition marks `angle` as valid.
- angle  in  19  phasecalc result. Signed Q9.10 degrees, range −180.0..+180.0 (±184320 LSB).
- delta  out  19  wrapped phase difference. Signed Q9.10 degrees, range (−180,+180].
- delta_valid  out  1  one-cycle strobe; `delta` is valid while it is high.
- avg  out  19+LOG2N..19  mean of the last 2^LOG2N deltas, signed Q9.10, 19 bits.
- avg_valid  out  1  one-cycle strobe; `avg` is valid while it is high.

## Operation
- Reset values:
  - outputs: `delta`=0, `avg`=0, `delta_valid`=0, `avg_valid`=0.
  - internal: `busy_q`=0, `prev`=0, `acc`=0, `cnt`=0, state=FIRST.
- Done detect: `done` = `busy_q` & ~`busy`, where `busy_q` is `busy` registered. Because `busy_q` resets to 0, a low `busy` immediately after reset does not generate `done`.
- State FIRST:
  - on `done`: `prev` ← `angle`, go to RUN.
  - no `delta_valid` is generated in this state.
- State RUN, on `done`:
  - `cur` ← `angle` (stage 1).
  - next cycle: raw = `cur` − `prev`, a 20-bit signed value.
  - wrap rule: if raw > 184320, subtract 368640; if raw ≤ −184320, add 368640.
  - `delta` ← wrapped value truncated to 19 bits (lossless after the wrap). `prev` ← `cur`. `delta_valid` ← 1.
- Averager, on each `delta_valid`:
  - `acc` ← `acc` + sign-extended `delta`. `acc` is 19+LOG2N bits and cannot overflow.
  - `cnt` increments; `cnt` is LOG2N bits and wraps.
  - when `cnt` wraps from 2^LOG2N−1: `avg` ← (`acc` + `delta`) >>> LOG2N (arithmetic shift, floor toward −∞), `avg_valid` ← 1, `acc` ← 0.
- Back-to-back `done` events are separated by at least 2 cycles, because phasecalc holds `busy` high for ≥1 cycle per calculation. The pipeline accepts one `done` every 2 cycles.
- Reset mid-operation:
  - any in-flight `delta` is discarded.
  - `acc` and `cnt` are cleared, and the state returns to FIRST.
  - the next `done` only reloads `prev`.
- A `done` coinciding with reset is ignored.

## Timing
- Let cycle T be the rising edge at which `busy`=0 is sampled with `busy_q`=1.
- `cur` is registered at T. `delta` and `delta_valid` are registered at T+1 and visible during cycle T+1..T+2.
- `avg` and `avg_valid` are registered at T+2 for the 2^LOG2N-th delta.
- Latency from `done` to `delta` is 2 edges. Latency from the final `done` to `avg` is 3 edges.
- Both strobes are high for exactly one cycle. `delta` and `avg` hold their values until the next update.

## Structure
- Package `hilbert_pkg` holds:
  - ANGLE_W = 19
  - ANGLE_FRAC = 10
  - DEG180 = 184320
  - DEG360 = 368640
- `phasecalc` already uses the Q9.10 angle format; it is to import the same package.
- Sub-module `phasewrap` (registered stage): takes `cur` and `prev`, produces `delta` and `delta_valid`.
- Top level `freqest` contains the done detector, the FIRST/RUN FSM and the averager.

## Test plan
- Reset → busy pulses with `angle` 10° (10240), then 30° (30720).
  - Required: no `delta_valid` on the first pulse.
  - Required: `delta`=20480 exactly 2 edges after the second falling edge of `busy`.
- Wrap positive: 170° (174080) → −170° (−174080) gives raw −348160; required `delta`=+20480.
- Wrap negative: −170° → 170° gives `delta`=−20480.
- Boundaries:
  - 0 → 180° (184320) gives `delta`=+184320.
  - 180° → 0 gives raw −184320; required `delta`=+184320.
  - 0 → −180° gives `delta`=+184320.
- Averaging, LOG2N=2:
  - deltas 1,2,3,6 → `avg`=3 with one `avg_valid`.
  - deltas −1,−1,−1,−2 → `avg`=−2 (floor).
  - no `avg_valid` on the first 3 deltas of either window.
- Reset asserted between `cur` capture and `delta` output → no `delta_valid`; the next two `done` events produce exactly one `delta`.
